// File: rtl/aux_channel.sv
// DisplayPort AUX native request/reply engine: Manchester-II TX framing, reply SYNC-END detect and decode.
// Optional DEFER retry behaviour is enabled by defining AUX_DEFER_RETRY_EN.
module aux_channel #(
    parameter int HALFBIT  = 50,
    parameter int TIMEOUT  = 40000,
    parameter int PREAMBLE = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] auxaddr,
    input  logic [7:0]  auxwdata,
    input  logic        auxwr,
    input  logic        auxreq,
    output logic        auxack,
    output logic        auxerr,
    output logic [7:0]  auxrdata,
    output logic        aux_tx,
    output logic        aux_oe,
    input  logic        aux_rx
);

    localparam int CW = $clog2(TIMEOUT + 8*HALFBIT + 4*PREAMBLE + 128);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TX_SYNC  = 3'd1;
    localparam logic [2:0] TX_BYTES = 3'd2;
    localparam logic [2:0] TX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;
    localparam logic [2:0] RX_BYTES = 3'd5;
    localparam logic [2:0] HOLD     = 3'd6;
`ifdef AUX_DEFER_RETRY_EN
    localparam logic [2:0] DEFER_WAIT = 3'd7;
`endif

    localparam logic [CW-1:0] HB_LAST    = CW'(HALFBIT - 1);
    localparam logic [CW-1:0] PRE_HALVES = CW'(2*PREAMBLE);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(2*PREAMBLE + 7);
    localparam logic [CW-1:0] RD_LAST    = CW'(63);
    localparam logic [CW-1:0] WR_LAST    = CW'(79);
    localparam logic [CW-1:0] STOP_LAST  = CW'(7);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] RUN_MIN    = CW'(3*HALFBIT);
    localparam logic [CW-1:0] SAMPLE_PT  = CW'(HALFBIT/2);
    localparam logic [CW-1:0] MID_PT     = CW'(HALFBIT);
    localparam logic [CW-1:0] WIN_HI     = CW'(HALFBIT + HALFBIT/2);
    localparam logic [CW-1:0] BIT_LAST   = CW'(2*HALFBIT - 1);

    logic [2:0]    state;
    logic [CW-1:0] hcnt, hidx, tcnt, pcnt, run_cnt;
    logic [CW-1:0] last_half, sync_off, cur_run, pcnt_next;
    logic [3:0]    bit_cnt;
    logic [19:0]   req_addr;
    logic [7:0]    req_data;
    logic          req_wr;
    logic [39:0]   tx_shift, frame;
    logic [7:0]    rx_shift, rx_byte;
    logic          rx_prev, armed, rx_edge, sync_hit, sample_now, realign;
`ifdef AUX_DEFER_RETRY_EN
    logic [2:0]    retry_cnt;
`endif

    assign frame = {(req_wr ? 4'b1000 : 4'b1001), req_addr, 8'h00, req_data};

    // Line drive is decoded from the half-bit index so the frame layout is visible in one place.
    always_comb begin
        aux_oe    = 1'b0;
        aux_tx    = 1'b0;
        last_half = STOP_LAST;
        sync_off  = hidx - PRE_HALVES;
        case (state)
            TX_SYNC: begin
                aux_oe    = 1'b1;
                last_half = SYNC_LAST;
                aux_tx    = (hidx < PRE_HALVES) ? hidx[0] : (sync_off < CW'(4));
            end
            TX_BYTES: begin
                aux_oe    = 1'b1;
                last_half = req_wr ? WR_LAST : RD_LAST;
                aux_tx    = tx_shift[39] ^ hidx[0];
            end
            TX_STOP: begin
                aux_oe = 1'b1;
                aux_tx = (hidx < CW'(4));
            end
            default: ;
        endcase
    end

    assign rx_edge    = (aux_rx != rx_prev);
    assign cur_run    = rx_edge ? CW'(1) : run_cnt + CW'(1);
    assign sync_hit   = armed && !aux_rx && (cur_run == RUN_MIN);
    assign sample_now = (pcnt == SAMPLE_PT);
    assign realign    = rx_edge && (pcnt > SAMPLE_PT) && (pcnt <= WIN_HI);
    assign rx_byte    = {rx_shift[6:0], aux_rx};
    // pcnt counts cycles within a reply bit; a mid-bit edge pins the phase back to HALFBIT.
    assign pcnt_next  = realign ? (MID_PT + CW'(1)) :
                        (pcnt == BIT_LAST) ? '0 : pcnt + CW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            auxack    <= 1'b0;
            auxerr    <= 1'b0;
            auxrdata  <= '0;
            hcnt      <= '0;
            hidx      <= '0;
            tcnt      <= '0;
            pcnt      <= '0;
            run_cnt   <= '0;
            bit_cnt   <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_wr    <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_prev   <= 1'b0;
            armed     <= 1'b0;
`ifdef AUX_DEFER_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            auxack  <= 1'b0;
            rx_prev <= aux_rx;
            case (state)
                IDLE: begin
                    if (auxreq) begin
                        req_addr <= auxaddr;
                        req_data <= auxwdata;
                        req_wr   <= auxwr;
                        hcnt     <= '0;
                        hidx     <= '0;
                        state    <= TX_SYNC;
`ifdef AUX_DEFER_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                TX_SYNC, TX_BYTES, TX_STOP: begin
                    if (hcnt == HB_LAST) begin
                        hcnt <= '0;
                        if (hidx == last_half) begin
                            hidx <= '0;
                            if (state == TX_SYNC) begin
                                state    <= TX_BYTES;
                                tx_shift <= frame;
                            end else if (state == TX_BYTES) begin
                                state <= TX_STOP;
                            end else begin
                                state   <= RX_WAIT;
                                tcnt    <= '0;
                                run_cnt <= '0;
                                armed   <= 1'b0;
                            end
                        end else begin
                            hidx <= hidx + CW'(1);
                            if (state == TX_BYTES && hidx[0])
                                tx_shift <= {tx_shift[38:0], 1'b0};
                        end
                    end else begin
                        hcnt <= hcnt + CW'(1);
                    end
                end
                RX_WAIT: begin
                    tcnt    <= tcnt + CW'(1);
                    run_cnt <= cur_run;
                    if (rx_edge)
                        armed <= !aux_rx && (run_cnt >= RUN_MIN);
                    if (tcnt == TO_LAST) begin
                        auxack <= 1'b1;
                        auxerr <= 1'b1;
                        state  <= HOLD;
                    end else if (sync_hit) begin
                        state   <= RX_BYTES;
                        pcnt    <= MID_PT;
                        bit_cnt <= '0;
                    end
                end
                RX_BYTES: begin
                    pcnt <= pcnt_next;
                    if (sample_now) begin
                        rx_shift <= rx_byte;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (rx_byte[7:4])
                                4'b0000: begin
                                    if (req_wr) begin
                                        auxack <= 1'b1;
                                        auxerr <= 1'b0;
                                        state  <= HOLD;
                                    end
                                end
`ifdef AUX_DEFER_RETRY_EN
                                4'b0010: begin
                                    if (retry_cnt == 3'd7) begin
                                        auxack <= 1'b1;
                                        auxerr <= 1'b1;
                                        state  <= HOLD;
                                    end else begin
                                        retry_cnt <= retry_cnt + 3'd1;
                                        tcnt      <= '0;
                                        state     <= DEFER_WAIT;
                                    end
                                end
`endif
                                default: begin
                                    auxack <= 1'b1;
                                    auxerr <= 1'b1;
                                    state  <= HOLD;
                                end
                            endcase
                        end else if (bit_cnt == 4'd15) begin
                            auxrdata <= rx_byte;
                            auxack   <= 1'b1;
                            auxerr   <= 1'b0;
                            state    <= HOLD;
                        end
                    end
                end
`ifdef AUX_DEFER_RETRY_EN
                DEFER_WAIT: begin
                    tcnt <= tcnt + CW'(1);
                    if (tcnt == TO_LAST) begin
                        hcnt  <= '0;
                        hidx  <= '0;
                        state <= TX_SYNC;
                    end
                end
`endif
                HOLD: begin
                    if (!auxreq)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aux_channel.md
Name: aux_channel

Overview:
- DisplayPort AUX channel transaction engine, directly downstream of the register/bus block.
- Consumes the single-byte AUX request interface (auxaddr/auxwdata/auxwr/auxreq) and serialises it as a Manchester-II native AUX request.
- Receives and decodes the sink's reply, then returns auxack/auxerr/auxrdata to the register block.
- Line-side pins (aux_tx, aux_oe, aux_rx) connect to the AUX transceiver; aux_rx arrives already synchronised to clk.

Parameters:
- HALFBIT, 50, clk cycles per half unit interval (UI); 50 at 100 MHz gives 1 Mbit/s.
- TIMEOUT, 40000, clk cycles from end of request STOP to reply SYNC-END before error (400 us).
- PREAMBLE, 16, number of Manchester zeros sent before SYNC-END.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- auxaddr  in  20  DPCD address
- auxwdata  in  8  write data byte
- auxwr  in  1  1=native write, 0=native read
- auxreq  in  1  request level, held high until auxack
- auxack  out  1  one-cycle completion pulse
- auxerr  out  1  error status, valid with auxack
- auxrdata  out  8  read data, valid with auxack
- aux_tx  out  1  serial line drive value
- aux_oe  out  1  transceiver drive enable
- aux_rx  in  1  synchronised serial line input

Behaviour:
Reset:
- rstn low asynchronously forces: state=IDLE, auxack=0, auxerr=0, auxrdata=0, aux_tx=0, aux_oe=0; all counters cleared.
- Reset mid-transaction abandons the transaction with no ack.

Handshake:
- Request accepted in IDLE when auxreq=1. Address and data are latched on that cycle.
- auxack is a single-cycle pulse; auxerr and auxrdata are updated on the same cycle and hold until the next ack.
- After ack, state=HOLD until auxreq=0; then IDLE. A stale high auxreq is never re-accepted.

Encoding:
- Bit 1 = high for HALFBIT then low for HALFBIT.
- Bit 0 = low then high.
- Bytes are sent MSB first.

Request frame (TX_SYNC, TX_BYTES, TX_STOP):
- aux_oe=1 throughout the frame.
- PREAMBLE zeros, then SYNC-END (high 4 half-bits, low 4 half-bits).
- Bytes: {cmd,addr[19:16]}, addr[15:8], addr[7:0], 8'h00 (length-1), then auxwdata for a write only.
- cmd: 4'b1000 for write, 4'b1001 for read.
- STOP: high 4 half-bits, low 4 half-bits.
- Then aux_oe=0 and aux_tx=0.

Reply wait (RX_WAIT):
- Timeout counter starts at the end of STOP.
- SYNC-END detect: aux_rx high for ≥3·HALFBIT, a falling edge, then low for ≥3·HALFBIT.
- Reaching TIMEOUT before detection gives auxerr=1 and ack.

Reply decode (RX_BYTES):
- Bit 0 of the reply starts 4·HALFBIT after the SYNC-END falling edge.
- Each bit is sampled at bit_start+HALFBIT/2.
- A mid-bit transition seen within ±HALFBIT/2 of the expected point re-aligns bit timing.
- Byte 0 is the reply code: bits[7:4]=0000 ACK, 0001 NACK, 0010 DEFER; any other value is treated as NACK.
- Read ACK: decode a second byte into auxrdata, then ack with auxerr=0.
- Write ACK: ack immediately after byte 0 with auxerr=0; auxrdata unchanged.
- NACK: auxerr=1 and ack.
- DEFER: see Optional Feature.
- The reply STOP pattern is not checked.

Boundaries and width rules:
- aux_rx is ignored while aux_oe=1.
- auxreq deasserting mid-transaction is ignored; the transaction completes and acks.
- All counters are sized to hold TIMEOUT and 8·HALFBIT without wrap.

Optional Feature:
- Macro: AUX_DEFER_RETRY_EN.
- Defined:
  - A DEFER reply enters DEFER_WAIT for TIMEOUT cycles, then re-sends the identical request from TX_SYNC.
  - Up to 7 retries. An 8th DEFER gives auxerr=1 and ack.
  - The retry counter is cleared on every newly accepted request.
- Undefined: DEFER is treated like NACK (auxerr=1, ack); no retry logic is synthesised.

Test Plan:
- Write: auxaddr=20'h00100, auxwdata=8'h0A, auxwr=1 -> aux_tx emits 16 zeros, SYNC-END, bytes 80,01,00,00,0A, STOP. Bench replies ACK 8'h00 -> one auxack pulse, auxerr=0.
- Read: auxaddr=20'h00000, auxwr=0 -> bytes 90,00,00,00. Reply 8'h00 then 8'hA5 -> auxack with auxrdata=8'hA5, auxerr=0.
- NACK: reply 8'h10 -> auxack, auxerr=1. Hold auxreq high 100 cycles after ack -> no second transaction starts.
- Timeout: no reply -> auxack exactly TIMEOUT cycles after STOP ends, auxerr=1, aux_oe=0 throughout.
- DEFER (macro defined): reply 8'h20 twice then ACK -> three identical request frames, single auxack, auxerr=0. Macro undefined: first DEFER -> auxerr=1.
- Reset: drop rstn mid-TX_BYTES -> aux_oe=0, aux_tx=0 immediately, no ack. After release, a new auxreq starts a fresh full frame.
